// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter in front of a registered signed add/subtract unit.
// Define ADDSUB_ARB_SATURATE_EN to clamp overflowing results to the signed range.
module addsub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req0_m,
  input  logic             req1_m,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_ovf
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e           state_q;
  logic             last_q, m_q, id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             rsp_valid_q, rsp_id_q, rsp_ovf_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             gnt, ovf_d;
  logic [WIDTH-1:0] b_eff, sum_d, res_d;
  // On a tie the requester not granted last wins; a lone requester always wins.
  assign gnt        = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = ~rst & (state_q == IDLE) & req0_valid & ~gnt;
  assign req1_ready = ~rst & (state_q == IDLE) & req1_valid & gnt;
  assign b_eff      = m_q ? ~b_q : b_q;
  assign sum_d      = a_q + b_eff + WIDTH'(m_q);
  assign ovf_d      = (a_q[WIDTH-1] == b_eff[WIDTH-1]) & (sum_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_ARB_SATURATE_EN
  assign res_d = ovf_d ? (a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : sum_d;
`else
  assign res_d = sum_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req0_valid | req1_valid) begin
          a_q     <= gnt ? req1_a : req0_a;
          b_q     <= gnt ? req1_b : req0_b;
          m_q     <= gnt ? req1_m : req0_m;
          id_q    <= gnt;
          last_q  <= gnt;
          state_q <= EXEC;
        end
        EXEC: begin
          rsp_sum_q   <= res_d;
          rsp_ovf_q   <= ovf_d;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed and randomized checks of addsub_arbiter against a transaction-level model.
module tb_addsub_arbiter;
  logic       clk = 0, rst = 1;
  logic       req0_valid = 0, req1_valid = 0, req0_m = 0, req1_m = 0, rsp_ready = 1;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ovf;
  logic [7:0] rsp_sum;
  int checks = 0, failures = 0;

  addsub_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_m(req0_m), .req1_m(req1_m),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // Transaction-level model: phase 0 waiting, 1 computing, 2 presenting result.
  int         mphase = 0;
  bit         mlive = 0, mlast = 1, movf = 0, mid = 0;
  logic [7:0] msum = 0;

  always @(negedge clk) begin
    bit e0, e1;
    int sa, sb, r;
    e0 = !rst && mphase == 0 && req0_valid && (!req1_valid || mlast);
    e1 = !rst && mphase == 0 && req1_valid && (!req0_valid || !mlast);
    if (mlive) begin
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("rsp_valid", rsp_valid, mphase == 2);
      if (mphase == 2) begin
        chk("rsp_sum", rsp_sum, msum);
        chk("rsp_ovf", rsp_ovf, movf);
        chk("rsp_id", rsp_id, mid);
      end
    end
    if (rst) begin
      mlive = 1; mphase = 0; mlast = 1;
    end else if (mphase == 0 && (e0 || e1)) begin
      mid = e1; mlast = e1;
      sa = e1 ? $signed(req1_a) : $signed(req0_a);
      sb = e1 ? $signed(req1_b) : $signed(req0_b);
      r = (e1 ? req1_m : req0_m) ? sa - sb : sa + sb;
      movf = r > 127 || r < -128;
      msum = r[7:0];
`ifdef ADDSUB_ARB_SATURATE_EN
      if (movf) msum = sa >= 0 ? 8'h7F : 8'h80;
`endif
      mphase = 1;
    end else if (mphase == 1) mphase = 2;
    else if (mphase == 2 && rsp_ready) mphase = 0;
  end

  function automatic logic [7:0] rnd();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      4: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic issue(bit id, logic [7:0] a, logic [7:0] b, bit m, logic [7:0] es, bit eo);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_m = m; end
    else begin req0_valid = 1; req0_a = a; req0_b = b; req0_m = m; end
    @(negedge clk) chk("accept_ready", id ? req1_ready : req0_ready, 1);
    @(posedge clk); #1; req0_valid = 0; req1_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("dir_valid", rsp_valid, 1);
    chk("dir_sum", rsp_sum, es);
    chk("dir_ovf", rsp_ovf, eo);
    chk("dir_id", rsp_id, id);
    @(posedge clk); #1;
  endtask

  initial begin
    int gid[$], gt[$];
    req0_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_ovf", rsp_ovf, 0);
    chk("rst_id", rsp_id, 0);
    @(posedge clk); #1; rst = 0; req0_valid = 0;
    issue(0, 8'h05, 8'h03, 0, 8'h08, 0);
`ifdef ADDSUB_ARB_SATURATE_EN
    issue(1, 8'h7F, 8'h01, 0, 8'h7F, 1);
    issue(0, 8'h80, 8'h01, 1, 8'h80, 1);
`else
    issue(1, 8'h7F, 8'h01, 0, 8'h80, 1);
    issue(0, 8'h80, 8'h01, 1, 8'h7F, 1);
`endif
    issue(0, 8'h03, 8'h05, 1, 8'hFE, 0);
    // Round-robin with both requesters held valid after a fresh reset.
    rst = 1; @(posedge clk); #1; rst = 0;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready) begin gid.push_back(0); gt.push_back(c); end
      if (req1_ready) begin gid.push_back(1); gt.push_back(c); end
      @(posedge clk); #1;
      req0_a = rnd(); req0_b = rnd(); req0_m = 1'($urandom);
      req1_a = rnd(); req1_b = rnd(); req1_m = 1'($urandom);
    end
    chk("rr_count", gid.size(), 4);
    for (int k = 0; k < 4 && k < gid.size(); k++) begin
      chk("rr_id", gid[k], k % 2);
      chk("rr_time", gt[k], 3 * k);
    end
    // Backpressure: result must hold for four stalled cycles.
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_valid = 1; req0_a = 8'h10; req0_b = 8'h20; req0_m = 0;
    @(negedge clk) chk("bp_accept", req0_ready, 1);
    @(posedge clk); #1; req1_valid = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_sum", rsp_sum, 8'h30);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1; req0_valid = 0; req1_valid = 0;
    @(negedge clk) chk("bp_release", rsp_valid, 1);
    @(posedge clk); #1;
    @(negedge clk) chk("bp_idle", rsp_valid, 0);
    @(posedge clk); #1;
    // Reset while computing discards the operation and restores requester 0 priority.
    req0_valid = 1; req0_a = 8'h22; req0_b = 8'h11;
    @(negedge clk) chk("rx_accept", req0_ready, 1);
    @(posedge clk); #1; rst = 1; req1_valid = 1;
    @(negedge clk);
    chk("rx_ready0", req0_ready, 0);
    chk("rx_ready1", req1_ready, 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("rx_valid", rsp_valid, 0);
    chk("rx_gnt0", req0_ready, 1);
    chk("rx_gnt1", req1_ready, 0);
    @(posedge clk); #1; req0_valid = 0; req1_valid = 0;
    repeat (3) @(posedge clk); #1;
    // Randomized traffic, backpressure and occasional resets, checked by the model.
    for (int c = 0; c < 600; c++) begin
      req0_valid = $urandom_range(0, 2) != 0;
      req1_valid = $urandom_range(0, 2) != 0;
      req0_a = rnd(); req0_b = rnd(); req0_m = 1'($urandom);
      req1_a = rnd(); req1_b = rnd(); req1_m = 1'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      @(posedge clk); #1;
    end
    rst = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
